// File: rtl/cpu_ctrl_pkg.sv
// Shared CPU control definitions: interrupt sequencer states, default widths,
// vector location and the data-memory command encoding used by the arbiter.
package cpu_ctrl_pkg;

  localparam int unsigned AW_DEF = 8;
  localparam int unsigned FW_DEF = 4;
  localparam logic [7:0] VEC_ADDR_DEF = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_PC,
    S_PUSH_FLG,
    S_FETCH_VEC,
    S_JUMP,
    S_RTI_POP_FLG,
    S_RTI_POP_PC
  } seq_state_e;

  typedef enum logic {
    MEM_RD = 1'b0,
    MEM_WR = 1'b1
  } mem_cmd_e;

endpackage

// File: rtl/intr_sequencer.sv
// Interrupt entry / RTI sequencer: drains the pipeline, pushes PC and flags,
// fetches the vector and redirects the PC; RTI pops flags then PC.
module intr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned     AW       = AW_DEF,
  parameter int unsigned     FW       = FW_DEF,
  parameter logic [AW-1:0]   VEC_ADDR = AW'(VEC_ADDR_DEF)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          intr_flag,
  output logic          inter_en,
  output logic          intr_clear,
  input  logic          gie,
  input  logic          hlt_flag,
  output logic          hlt_wake,
  input  logic          rti_req,
  input  logic          pipe_empty,
  output logic          stall,
  output logic          flush,
  input  logic [AW-1:0] pc_cur,
  input  logic [FW-1:0] flags_cur,
  input  logic [AW-1:0] sp_value,
  output logic          sp_dec,
  output logic          sp_inc,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  input  logic [7:0]    mem_rdata,
  input  logic          mem_ready,
  output logic          pc_load,
  output logic [AW-1:0] pc_load_val,
  output logic          flags_load,
  output logic [FW-1:0] flags_load_val,
  output logic          busy
);

  seq_state_e    state;
  logic [AW-1:0] ret_pc;
  logic [FW-1:0] ret_flg;
  logic [AW-1:0] vector;
  mem_cmd_e      cmd;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      ret_pc  <= '0;
      ret_flg <= '0;
      vector  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rti_req)                state <= S_RTI_POP_FLG;
          else if (intr_flag && gie)  state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pipe_empty) begin
            ret_pc  <= pc_cur;
            ret_flg <= flags_cur;
            state   <= S_PUSH_PC;
          end
        end
        S_PUSH_PC:     if (mem_ready) state <= S_PUSH_FLG;
        S_PUSH_FLG:    if (mem_ready) state <= S_FETCH_VEC;
        S_FETCH_VEC: begin
          if (mem_ready) begin
            vector <= AW'(mem_rdata);
            state  <= S_JUMP;
          end
        end
        S_JUMP:        state <= S_IDLE;
        S_RTI_POP_FLG: if (mem_ready) state <= S_RTI_POP_PC;
        S_RTI_POP_PC:  if (mem_ready) state <= S_IDLE;
        default:       state <= S_IDLE;
      endcase
    end
  end

  assign inter_en = gie && (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  // Handshake pulses are decoded from state and mem_ready so they fall in the
  // ready cycle itself; reset gates everything so no partial access completes.
  always_comb begin
    intr_clear     = 1'b0;
    hlt_wake       = 1'b0;
    stall          = 1'b0;
    flush          = 1'b0;
    sp_dec         = 1'b0;
    sp_inc         = 1'b0;
    mem_req        = 1'b0;
    cmd            = MEM_RD;
    mem_addr       = '0;
    mem_wdata      = '0;
    pc_load        = 1'b0;
    pc_load_val    = '0;
    flags_load     = 1'b0;
    flags_load_val = '0;
    if (rst) begin
      case (state)
        S_IDLE: hlt_wake = !rti_req && intr_flag && gie && hlt_flag;
        S_DRAIN: begin
          stall = 1'b1;
          flush = pipe_empty;
        end
        S_PUSH_PC: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          cmd       = MEM_WR;
          mem_addr  = sp_value;
          mem_wdata = 8'(ret_pc);
          sp_dec    = mem_ready;
        end
        S_PUSH_FLG: begin
          stall     = 1'b1;
          mem_req   = 1'b1;
          cmd       = MEM_WR;
          mem_addr  = sp_value;
          mem_wdata = 8'(ret_flg);
          sp_dec    = mem_ready;
        end
        S_FETCH_VEC: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = VEC_ADDR;
        end
        S_JUMP: begin
          stall       = 1'b1;
          pc_load     = 1'b1;
          pc_load_val = vector;
          intr_clear  = 1'b1;
        end
        S_RTI_POP_FLG: begin
          stall      = 1'b1;
          mem_req    = 1'b1;
          mem_addr   = sp_value + AW'(1);
          sp_inc     = mem_ready;
          flags_load = mem_ready;
          if (mem_ready) flags_load_val = mem_rdata[FW-1:0];
        end
        S_RTI_POP_PC: begin
          stall    = 1'b1;
          mem_req  = 1'b1;
          mem_addr = sp_value + AW'(1);
          sp_inc   = mem_ready;
          pc_load  = mem_ready;
          flush    = mem_ready;
          if (mem_ready) pc_load_val = AW'(mem_rdata);
        end
        default: ;
      endcase
    end
  end

  assign mem_we = mem_req && (cmd == MEM_WR);

endmodule
